// File: rtl/vdac_sar_ctrl.sv
// -----------------------------------------------------------------------------
// vdac_sar_ctrl
//
// Successive-approximation controller for a bank of vdac_cell tri-state DAC
// slices. A conversion resolves the sign first and then each magnitude bit,
// MSB first. Every step drives a trial code onto the slices, waits for the DAC
// to settle, samples the synchronised comparator, and keeps or clears the
// trial bit. The result is reported in sign-magnitude form.
//
// Parameters:
//   DAC_BITS       result width (sign + DAC_BITS-1 magnitude bits), >= 2
//   SETTLE_CYCLES  settle cycles before each decision, >= 2 so that the
//                  two-flop comparator synchroniser has caught up
//
// Ports:
//   i_clk          clock for all logic
//   i_rst_n        asynchronous active-low reset
//   i_start        conversion request, only honoured while idle
//   i_cmp          asynchronous comparator (1: sensed voltage above DAC)
//   o_dac_sign     common i_sign for every slice
//   o_dac_data     per-magnitude-bit i_data
//   o_dac_enable   per-magnitude-bit i_enable
//   o_busy         conversion in progress (settle/decide phases)
//   o_done         one-cycle pulse when o_result updates
//   o_result       {sign, magnitude} of the last completed conversion
//
// Build option:
//   VDAC_SAR_HOLD_EN  when defined, the final code stays applied to the DAC
//                     (enables held high) after the first completed
//                     conversion, until the next start or reset. When
//                     undefined, the slices float between conversions.
// -----------------------------------------------------------------------------
module vdac_sar_ctrl #(
   parameter int DAC_BITS      = 6,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic                i_cmp,
   output logic                o_dac_sign,
   output logic [DAC_BITS-2:0] o_dac_data,
   output logic [DAC_BITS-2:0] o_dac_enable,
   output logic                o_busy,
   output logic                o_done,
   output logic [DAC_BITS-1:0] o_result
);

   localparam int MAG_BITS = DAC_BITS - 1;
   // Step index width; a single magnitude bit still needs a 1-bit index.
   localparam int KW = (MAG_BITS > 1) ? $clog2(MAG_BITS) : 1;
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [KW-1:0] K_TOP    = KW'(MAG_BITS - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_DECIDE,
      ST_DONE
   } state_t;

   // ------------------------------------------------------------------
   // State and trial registers
   // ------------------------------------------------------------------
   state_t              state_q,     state_d;
   logic                sign_q,      sign_d;
   logic [MAG_BITS-1:0] mag_q,       mag_d;
   logic [KW-1:0]       k_q,         k_d;
   logic                sign_step_q, sign_step_d;
   logic [CW-1:0]       cnt_q,       cnt_d;

   // Comparator synchroniser
   logic                cmp_s1_q,    cmp_s1_d;
   logic                cmp_s2_q,    cmp_s2_d;

   // Registered outputs
   logic                dac_sign_q,   dac_sign_d;
   logic [MAG_BITS-1:0] dac_data_q,   dac_data_d;
   logic [MAG_BITS-1:0] dac_enable_q, dac_enable_d;
   logic                busy_q,       busy_d;
   logic                done_q,       done_d;
   logic [DAC_BITS-1:0] result_q,     result_d;

`ifdef VDAC_SAR_HOLD_EN
   // Set once any conversion has completed; cleared only by reset.
   logic                held_q,       held_d;
`endif

   logic                keep_bit;
   logic [KW-1:0]       k_dec;
   logic                enable_on_d;

   // A magnitude trial bit survives when the comparator agrees with the
   // sign: for a positive code the input must still be above the DAC, for
   // a negative code it must be at or below it.
   assign keep_bit = (sign_q & cmp_s2_q) | (~sign_q & ~cmp_s2_q);
   assign k_dec    = k_q - KW'(1);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      mag_d       = mag_q;
      k_d         = k_q;
      sign_step_d = sign_step_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      done_d      = 1'b0;
      cmp_s1_d    = i_cmp;
      cmp_s2_d    = cmp_s1_q;
`ifdef VDAC_SAR_HOLD_EN
      held_d      = held_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               sign_d      = 1'b0;
               mag_d       = '0;
               sign_step_d = 1'b1;
               k_d         = K_TOP;
               cnt_d       = '0;
               state_d     = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_DECIDE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_DECIDE: begin
            if (sign_step_q) begin
               // Zero code was applied: comparator directly gives the sign.
               sign_d           = cmp_s2_q;
               mag_d[K_TOP]     = 1'b1;
               sign_step_d      = 1'b0;
               state_d          = ST_SETTLE;
            end else begin
               mag_d[k_q] = keep_bit;
               if (k_q != '0) begin
                  mag_d[k_dec] = 1'b1;
                  k_d          = k_dec;
                  state_d      = ST_SETTLE;
               end else begin
                  // Result and done are registered on entry so they are
                  // visible during the single DONE cycle.
                  result_d = {sign_q, mag_d};
                  done_d   = 1'b1;
                  state_d  = ST_DONE;
`ifdef VDAC_SAR_HOLD_EN
                  held_d   = 1'b1;
`endif
               end
            end
         end

         ST_DONE: begin
            // A start arriving here is dropped on purpose; it only counts
            // if it is still present once the FSM is back in IDLE.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode, computed from next-state values so the registered
   // outputs line up with the state they describe.
   // ------------------------------------------------------------------
   assign busy_d     = (state_d == ST_SETTLE) || (state_d == ST_DECIDE);
   assign dac_sign_d = sign_d;

`ifdef VDAC_SAR_HOLD_EN
   // Drive the slices whenever a conversion is running or has finished at
   // least once, so the last code remains applied between conversions.
   assign enable_on_d = (state_d != ST_IDLE) || held_d;
`else
   assign enable_on_d = busy_d;
`endif

   // Slice mapping: a set magnitude bit pulls its slice to the rail chosen
   // by the sign, a clear bit leaves it at mid-level. With sign=0 that means
   // i_data is the inverted magnitude bit.
   generate
      for (genvar gi = 0; gi < MAG_BITS; gi++) begin : g_slice
         assign dac_data_d[gi]   = sign_d ? mag_d[gi] : ~mag_d[gi];
         assign dac_enable_d[gi] = enable_on_d;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         sign_q       <= 1'b0;
         mag_q        <= '0;
         k_q          <= '0;
         sign_step_q  <= 1'b0;
         cnt_q        <= '0;
         cmp_s1_q     <= 1'b0;
         cmp_s2_q     <= 1'b0;
         dac_sign_q   <= 1'b0;
         dac_data_q   <= '1;
         dac_enable_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         result_q     <= '0;
`ifdef VDAC_SAR_HOLD_EN
         held_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sign_q       <= sign_d;
         mag_q        <= mag_d;
         k_q          <= k_d;
         sign_step_q  <= sign_step_d;
         cnt_q        <= cnt_d;
         cmp_s1_q     <= cmp_s1_d;
         cmp_s2_q     <= cmp_s2_d;
         dac_sign_q   <= dac_sign_d;
         dac_data_q   <= dac_data_d;
         dac_enable_q <= dac_enable_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         result_q     <= result_d;
`ifdef VDAC_SAR_HOLD_EN
         held_q       <= held_d;
`endif
      end
   end

   assign o_dac_sign   = dac_sign_q;
   assign o_dac_data   = dac_data_q;
   assign o_dac_enable = dac_enable_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_result     = result_q;

endmodule

// File: tb/tb_vdac_sar_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for vdac_sar_ctrl (DAC_BITS=4, SETTLE_CYCLES=2).
// The comparator is modelled as cmp = vin > dac, with dac decoded from the
// slice controls. Expected results come from closed-form SAR arithmetic.
// -----------------------------------------------------------------------------
module tb_vdac_sar_ctrl;

   localparam int DAC_BITS      = 4;
   localparam int SETTLE_CYCLES = 2;
   localparam int MAG_BITS      = DAC_BITS - 1;
   localparam int STEP          = SETTLE_CYCLES + 1;
   localparam int CONV          = DAC_BITS * STEP;
   localparam int MAX_MAG       = (1 << MAG_BITS) - 1;

`ifdef VDAC_SAR_HOLD_EN
   localparam logic [MAG_BITS-1:0] EN_AFTER = '1;
`else
   localparam logic [MAG_BITS-1:0] EN_AFTER = '0;
`endif

   logic                clk   = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic                cmp;
   logic                dac_sign;
   logic [MAG_BITS-1:0] dac_data;
   logic [MAG_BITS-1:0] dac_enable;
   logic                busy;
   logic                done;
   logic [DAC_BITS-1:0] result;

   int   vin       = 0;
   logic force_en  = 1'b0;
   logic force_val = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Observations of the last run_conv call
   int                  obs_busy;
   int                  obs_busy_after;
   int                  obs_done_cyc;
   int                  obs_done_cnt;
   logic                obs_en_ok;
   logic [DAC_BITS-1:0] obs_result;
   logic [MAG_BITS-1:0] obs_done_en;
   logic [MAG_BITS-1:0] obs_idle_en;
   int                  obs_idle_dac;
   int                  obs_trials[DAC_BITS];

   always #5 clk = ~clk;

   // Signed DAC level implied by the slice controls.
   function automatic int dac_value(input logic s, input logic [MAG_BITS-1:0] d);
      int m;
      m = 0;
      for (int j = 0; j < MAG_BITS; j++)
         if ((s ? d[j] : ~d[j]) == 1'b1) m += (1 << j);
      return s ? m : -m;
   endfunction

   assign cmp = force_en ? force_val : (vin > dac_value(dac_sign, dac_data));

   // Closed form: positive inputs resolve to the largest magnitude strictly
   // below vin, non-positive inputs to -vin, both clipped to full scale.
   function automatic logic [DAC_BITS-1:0] exp_result(input int v);
      int m;
      if (v > 0) begin
         m = v - 1;
         if (m > MAX_MAG) m = MAX_MAG;
         return {1'b1, MAG_BITS'(m)};
      end
      m = -v;
      if (m > MAX_MAG) m = MAX_MAG;
      return {1'b0, MAG_BITS'(m)};
   endfunction

   function automatic int signed_code(input logic [DAC_BITS-1:0] r);
      logic [MAG_BITS-1:0] m;
      m = r[MAG_BITS-1:0];
      return r[DAC_BITS-1] ? int'(m) : -int'(m);
   endfunction

   // Signed DAC level of trial number idx (0 = the zero code of the sign step).
   function automatic int model_trial(input int v, input int idx);
      int  mag;
      int  t;
      int  dv;
      bit  s;
      mag = 0;
      s   = (v > 0);
      if (idx == 0) return 0;
      for (int b = MAG_BITS - 1; b >= 0; b--) begin
         t  = mag | (1 << b);
         dv = s ? t : -t;
         if (MAG_BITS - b == idx) return dv;
         if ((v > dv) == s) mag = t;
      end
      return 0;
   endfunction

   vdac_sar_ctrl #(
      .DAC_BITS      (DAC_BITS),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_cmp        (cmp),
      .o_dac_sign   (dac_sign),
      .o_dac_data   (dac_data),
      .o_dac_enable (dac_enable),
      .o_busy       (busy),
      .o_done       (done),
      .o_result     (result)
   );

   // Drives one start pulse and records what the DUT does; comparisons are
   // made by the calling test. Cycle 1 is the cycle after the start edge.
   task automatic run_conv(input int v);
      int cyc;
      int ti;
      vin = v;
      for (int i = 0; i < DAC_BITS; i++) obs_trials[i] = 9999;
      obs_busy     = 0;
      obs_done_cyc = -1;
      obs_done_cnt = 0;
      obs_en_ok    = 1'b1;
      obs_result   = 'x;
      obs_done_en  = 'x;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 1;
      ti  = 0;
      while (obs_done_cyc < 0 && cyc < 100) begin
         if (busy === 1'b1) begin
            obs_busy++;
            if (dac_enable !== {MAG_BITS{1'b1}}) obs_en_ok = 1'b0;
            if ((cyc - 1) % STEP == 0 && ti < DAC_BITS) begin
               obs_trials[ti] = dac_value(dac_sign, dac_data);
               ti++;
            end
         end
         if (done === 1'b1) begin
            obs_done_cyc = cyc;
            obs_done_cnt++;
            obs_result   = result;
            obs_done_en  = dac_enable;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      @(negedge clk);
      if (done === 1'b1) obs_done_cnt++;
      obs_busy_after = (busy === 1'b1) ? 1 : 0;
      obs_idle_en    = dac_enable;
      obs_idle_dac   = dac_value(dac_sign, dac_data);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      vin   = 0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++;
      if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
      n_checks++;
      if ({dac_sign, dac_data, dac_enable} !== {1'b0, {MAG_BITS{1'b1}}, {MAG_BITS{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_dac got sign=%b data=%b en=%b want sign=0 data=111 en=000",
                  dac_sign, dac_data, dac_enable);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || dac_enable !== '0) begin
         n_fail++;
         $display("FAIL reset_idle got busy=%b en=%b want busy=0 en=000", busy, dac_enable);
      end
      $display("test_reset: checks=%0d failures=%0d", n_checks, n_fail);
   endtask

   task automatic test_conversion(input int v);
      logic [DAC_BITS-1:0] exp_r;
      exp_r = exp_result(v);
      run_conv(v);
      n_checks++;
      if (obs_result !== exp_r) begin
         n_fail++; $display("FAIL conv_result vin=%0d got %h want %h", v, obs_result, exp_r);
      end
      n_checks++;
      if (obs_busy != CONV) begin
         n_fail++; $display("FAIL conv_busy_len vin=%0d got %0d want %0d", v, obs_busy, CONV);
      end
      n_checks++;
      if (obs_done_cyc != CONV + 1) begin
         n_fail++; $display("FAIL conv_done_cycle vin=%0d got %0d want %0d", v, obs_done_cyc, CONV + 1);
      end
      n_checks++;
      if (obs_done_cnt != 1 || obs_busy_after != 0) begin
         n_fail++; $display("FAIL conv_done_pulse vin=%0d got pulses=%0d busy_after=%0d want 1 and 0",
                            v, obs_done_cnt, obs_busy_after);
      end
      n_checks++;
      if (obs_en_ok !== 1'b1) begin
         n_fail++; $display("FAIL conv_enable_busy vin=%0d got not-all-ones want all-ones", v);
      end
      for (int i = 0; i < DAC_BITS; i++) begin
         n_checks++;
         if (obs_trials[i] != model_trial(v, i)) begin
            n_fail++; $display("FAIL conv_trial%0d vin=%0d got %0d want %0d", i, v, obs_trials[i], model_trial(v, i));
         end
      end
      n_checks++;
      if (obs_done_en !== EN_AFTER || obs_idle_en !== EN_AFTER) begin
         n_fail++; $display("FAIL conv_enable_after vin=%0d got done=%b idle=%b want %b",
                            v, obs_done_en, obs_idle_en, EN_AFTER);
      end
      n_checks++;
      if (obs_idle_dac != signed_code(exp_r)) begin
         n_fail++; $display("FAIL conv_final_code vin=%0d got %0d want %0d", v, obs_idle_dac, signed_code(exp_r));
      end
      $display("test_conversion vin=%0d result=%h done_cycle=%0d", v, obs_result, obs_done_cyc);
   endtask

   task automatic test_random();
      int v;
      logic [DAC_BITS-1:0] exp_r;
      for (int n = 0; n < 16; n++) begin
         v     = int'($urandom_range(0, 20)) - 10;
         exp_r = exp_result(v);
         run_conv(v);
         n_checks++;
         if (obs_result !== exp_r) begin
            n_fail++; $display("FAIL rand_result vin=%0d got %h want %h", v, obs_result, exp_r);
         end
         n_checks++;
         if (obs_done_cyc != CONV + 1 || obs_done_cnt != 1) begin
            n_fail++; $display("FAIL rand_done vin=%0d got cycle=%0d pulses=%0d want cycle=%0d pulses=1",
                               v, obs_done_cyc, obs_done_cnt, CONV + 1);
         end
         for (int i = 0; i < DAC_BITS; i++) begin
            n_checks++;
            if (obs_trials[i] != model_trial(v, i)) begin
               n_fail++; $display("FAIL rand_trial%0d vin=%0d got %0d want %0d", i, v, obs_trials[i], model_trial(v, i));
            end
         end
         $display("test_random vin=%0d result=%h", v, obs_result);
      end
   endtask

   // Spurious starts while busy, then start held through DONE into IDLE.
   task automatic test_back_to_back();
      int done_at[$];
      logic [DAC_BITS-1:0] res_at[$];
      logic busy14;
      logic busy15;
      busy14 = 1'bx;
      busy15 = 1'bx;
      vin = 6;
      @(negedge clk); start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 35; c++) begin
         if (done === 1'b1) begin done_at.push_back(c); res_at.push_back(result); end
         if (c == 14) busy14 = busy;
         if (c == 15) busy15 = busy;
         if (c == 13) vin = -5;
         start = (c == 3 || c == 5 || c == 9 || (c >= 11 && c <= 14)) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      n_checks++;
      if (done_at.size() != 2) begin
         n_fail++; $display("FAIL b2b_done_count got %0d want 2", done_at.size());
      end else begin
         n_checks++;
         if (done_at[0] != CONV + 1 || done_at[1] != 2 * CONV + 3) begin
            n_fail++; $display("FAIL b2b_done_cycles got %0d,%0d want %0d,%0d",
                               done_at[0], done_at[1], CONV + 1, 2 * CONV + 3);
         end
         n_checks++;
         if (res_at[0] !== exp_result(6) || res_at[1] !== exp_result(-5)) begin
            n_fail++; $display("FAIL b2b_results got %h,%h want %h,%h",
                               res_at[0], res_at[1], exp_result(6), exp_result(-5));
         end
      end
      n_checks++;
      if (busy14 !== 1'b0 || busy15 !== 1'b1) begin
         n_fail++; $display("FAIL b2b_restart got busy14=%b busy15=%b want 0 and 1", busy14, busy15);
      end
      $display("test_back_to_back: done_pulses=%0d", done_at.size());
   endtask

   // Comparator edges placed just after / just before the edge two cycles
   // ahead of the sign decision.
   task automatic test_sync();
      int waited;
      force_en  = 1'b1;
      force_val = 1'b0;

      // Case A: rise just after edge E0+1 -> missed by the sign decision.
      @(negedge clk); start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      @(posedge clk); #2 force_val = 1'b1;
      @(posedge clk); #8 force_val = 1'b0;
      waited = 0;
      while (done !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
      n_checks++;
      if (result !== 4'h7 || $isunknown(result)) begin
         n_fail++; $display("FAIL sync_late_edge got %h want 7", result);
      end
      $display("test_sync late edge result=%h", result);
      repeat (2) @(negedge clk);

      // Case B: rise just before edge E0+1 -> seen by the sign decision.
      @(negedge clk); start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      #6 force_val = 1'b1;
      @(posedge clk);
      @(posedge clk); #2 force_val = 1'b0;
      waited = 0;
      while (done !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
      n_checks++;
      if (result !== 4'h8 || $isunknown(result)) begin
         n_fail++; $display("FAIL sync_early_edge got %h want 8", result);
      end
      $display("test_sync early edge result=%h", result);
      repeat (2) @(negedge clk);
      force_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int dones;
      vin = 3;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || result === '0) begin
         n_fail++; $display("FAIL midrst_precond got busy=%b result=%h want busy=1 result!=0", busy, result);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL midrst_busy_done got busy=%b done=%b want 0 0", busy, done);
      end
      n_checks++;
      if (dac_enable !== 3'b000 || dac_data !== 3'b111 || dac_sign !== 1'b0) begin
         n_fail++; $display("FAIL midrst_dac got en=%b data=%b sign=%b want 000 111 0", dac_enable, dac_data, dac_sign);
      end
      n_checks++;
      if (result !== '0) begin
         n_fail++; $display("FAIL midrst_result got %h want 0", result);
      end
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
         if (i == 2) rst_n = 1'b1;
      end
      n_checks++;
      if (dones != 0 || busy !== 1'b0 || dac_enable !== '0) begin
         n_fail++; $display("FAIL midrst_after got dones=%0d busy=%b en=%b want 0 0 000", dones, busy, dac_enable);
      end
      $display("test_reset_mid: done_pulses=%0d", dones);
   endtask

   initial begin
      test_reset();
      test_conversion(5);
      test_conversion(-3);
      test_random();
      test_back_to_back();
      test_sync();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
